// File: rtl/key_if.sv
// key_if: raw key lines in, conditioned key levels/strobes/index out.
// master drives the raw lines; slave is the conditioner.
interface key_if #(
  parameter int N_KEYS = 4,
  parameter int IDX_W  = 2
);

  logic [N_KEYS-1:0] pressed;
  logic [N_KEYS-1:0] pressed_lvl;
  logic [N_KEYS-1:0] press_pulse;
  logic [N_KEYS-1:0] release_pulse;
  logic              any_pressed;
  logic [IDX_W-1:0]  key_idx;

  modport master (
    output pressed,
    input  pressed_lvl,
    input  press_pulse,
    input  release_pulse,
    input  any_pressed,
    input  key_idx
  );

  modport slave (
    input  pressed,
    output pressed_lvl,
    output press_pulse,
    output release_pulse,
    output any_pressed,
    output key_idx
  );

endinterface

// File: rtl/key_press_detect.sv
// key_press_detect: synchronise + debounce N_KEYS raw key lines.
// Define KEY_AUTOREPEAT_EN to re-fire press_pulse while a key is held.
module key_press_detect #(
  parameter int N_KEYS     = 4,
  parameter int IDX_W      = 2,
  parameter int CNT_W      = 16,
  parameter int DEB_CYCLES = 16,
  parameter int REPEAT_DLY = 5000,
  parameter int REPEAT_PER = 1000
) (
  input logic clk,
  input logic rst_n,
  key_if.slave kif
);

  localparam logic [CNT_W-1:0] DEB_M1 =
    CNT_W'(DEB_CYCLES - 1);
  localparam bit DEB_ONE = (DEB_CYCLES == 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEB_P = 2'd1,
    HELD  = 2'd2,
    DEB_R = 2'd3
  } st_t;

  if (N_KEYS < 1) begin : g_bad_keys
    $error("N_KEYS must be >= 1");
  end
  if ((1 << IDX_W) < N_KEYS) begin : g_bad_idx
    $error("IDX_W too narrow for N_KEYS");
  end
  if (DEB_CYCLES < 1 ||
      DEB_CYCLES > (1 << CNT_W) - 1) begin : g_bad_deb
    $error("DEB_CYCLES out of range");
  end
  if (REPEAT_DLY < 1 || REPEAT_PER < 1 ||
      REPEAT_DLY > (1 << CNT_W) - 1 ||
      REPEAT_PER > (1 << CNT_W) - 1) begin : g_bad_rpt
    $error("REPEAT_DLY/REPEAT_PER out of range");
  end

  logic [1:0] rst_q;
  logic       rst_i_n;

  // Reset asserts at once, releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_q <= 2'b00;
    end else begin
      rst_q <= {rst_q[0], 1'b1};
    end
  end

  assign rst_i_n = rst_q[1];

  logic [N_KEYS-1:0] s_meta;
  logic [N_KEYS-1:0] s;

  // Two-flop synchroniser for the raw key lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_meta <= '0;
      s      <= '0;
    end else begin
      s_meta <= kif.pressed;
      s      <= s_meta;
    end
  end

  logic [N_KEYS-1:0] lvl;
  logic [N_KEYS-1:0] prs;
  logic [N_KEYS-1:0] rel;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key

    st_t              st;
    st_t              st_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             armed;
    logic             armed_n;
    logic             lvl_q;
    logic             lvl_d;
    logic             prs_q;
    logic             prs_d;
    logic             rel_q;
    logic             rel_d;
    logic             fresh;
    logic             rpt_fire;

    // Debounce FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_i_n) begin
      if (!rst_i_n) begin
        st    <= IDLE;
        cnt   <= '0;
        armed <= 1'b0;
        lvl_q <= 1'b0;
        prs_q <= 1'b0;
        rel_q <= 1'b0;
      end else begin
        st    <= st_n;
        cnt   <= cnt_n;
        armed <= armed_n;
        lvl_q <= lvl_d;
        prs_q <= prs_d;
        rel_q <= rel_d;
      end
    end

    // Next state: count stable samples, drop back on a glitch.
    always_comb begin
      st_n    = st;
      cnt_n   = cnt;
      armed_n = armed | ((st == IDLE) & ~s[i]);
      unique case (st)
        IDLE: begin
          if (s[i]) begin
            if (DEB_ONE) begin
              st_n  = HELD;
              cnt_n = '0;
            end else begin
              st_n  = DEB_P;
              cnt_n = CNT_W'(1);
            end
          end
        end
        DEB_P: begin
          if (!s[i]) begin
            st_n  = IDLE;
            cnt_n = '0;
          end else if (cnt >= DEB_M1) begin
            st_n  = HELD;
            cnt_n = '0;
          end else if (cnt != '1) begin
            cnt_n = cnt + 1'b1;
          end
        end
        HELD: begin
          if (!s[i]) begin
            if (DEB_ONE) begin
              st_n  = IDLE;
              cnt_n = '0;
            end else begin
              st_n  = DEB_R;
              cnt_n = CNT_W'(1);
            end
          end
        end
        DEB_R: begin
          if (s[i]) begin
            st_n  = HELD;
            cnt_n = '0;
          end else if (cnt >= DEB_M1) begin
            st_n  = IDLE;
            cnt_n = '0;
          end else if (cnt != '1) begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          st_n  = IDLE;
          cnt_n = '0;
        end
      endcase
    end

    assign fresh = (st_n == HELD) &
                   ((st == IDLE) | (st == DEB_P));

    // Outputs from transitions; a key held through reset
    // qualifies its level without a press strobe.
    always_comb begin
      lvl_d = (st_n == HELD) | (st_n == DEB_R);
      prs_d = (fresh & armed) | rpt_fire;
      rel_d = (st_n == IDLE) &
              ((st == HELD) | (st == DEB_R));
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RDLY_M1 =
      CNT_W'(REPEAT_DLY - 1);
    localparam logic [CNT_W-1:0] RPER_M1 =
      CNT_W'(REPEAT_PER - 1);

    logic [CNT_W-1:0] rpt;
    logic [CNT_W-1:0] rpt_n;
    logic             first;
    logic             first_n;

    // Repeat counter state.
    always_ff @(posedge clk or negedge rst_i_n) begin
      if (!rst_i_n) begin
        rpt   <= '0;
        first <= 1'b0;
      end else begin
        rpt   <= rpt_n;
        first <= first_n;
      end
    end

    // Repeat timing: first gap REPEAT_DLY, then REPEAT_PER;
    // frozen outside HELD, cleared in IDLE.
    always_comb begin
      rpt_n    = rpt;
      first_n  = first;
      rpt_fire = 1'b0;
      if (st_n == IDLE) begin
        rpt_n   = '0;
        first_n = 1'b0;
      end else if (fresh) begin
        rpt_n   = '0;
        first_n = 1'b1;
      end else if (st == HELD && st_n == HELD) begin
        if (rpt >= (first ? RDLY_M1 : RPER_M1)) begin
          rpt_fire = 1'b1;
          rpt_n    = '0;
          first_n  = 1'b0;
        end else begin
          rpt_n = rpt + 1'b1;
        end
      end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    assign lvl[i] = lvl_q;
    assign prs[i] = prs_q;
    assign rel[i] = rel_q;
  end

  logic [IDX_W-1:0] idx_d;
  logic [IDX_W-1:0] idx_q;
  logic             any_q;

  // Lowest-numbered held key wins.
  always_comb begin
    idx_d = '0;
    for (int k = N_KEYS - 1; k >= 0; k--) begin
      if (lvl[k]) begin
        idx_d = IDX_W'(k);
      end
    end
  end

  // Summary flags lag the levels by one cycle.
  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      any_q <= 1'b0;
      idx_q <= '0;
    end else begin
      any_q <= |lvl;
      idx_q <= idx_d;
    end
  end

  assign kif.pressed_lvl   = lvl;
  assign kif.press_pulse   = prs;
  assign kif.release_pulse = rel;
  assign kif.any_pressed   = any_q;
  assign kif.key_idx       = idx_q;

endmodule

// File: tb/tb_key_press_detect.sv
// tb_key_press_detect: directed stimulus with a pulse scoreboard.
// Expected strobes are queued by the stimulus and popped by a monitor.
module tb_key_press_detect;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  key_if #(.N_KEYS(4), .IDX_W(2)) kif ();

  key_press_detect #(
    .N_KEYS(4),
    .IDX_W(2),
    .CNT_W(8),
    .DEB_CYCLES(4),
    .REPEAT_DLY(20),
    .REPEAT_PER(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .kif(kif.slave)
  );

  typedef struct {
    int         cyc;
    logic [3:0] prs;
    logic [3:0] rel;
  } exp_t;

  exp_t sb[$];

  task automatic expect_ev(int c, logic [3:0] p,
                           logic [3:0] r);
    exp_t e;
    e.cyc = c;
    e.prs = p;
    e.rel = r;
    sb.push_back(e);
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cyc %0d",
               name, act, exp, cyc);
    end
  endtask

  task automatic wait_to(int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Monitor: every strobe must match the queue head.
  always @(negedge clk) begin
    if (kif.press_pulse != 4'b0 ||
        kif.release_pulse != 4'b0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: cyc %0d press %b release %b",
                 cyc, kif.press_pulse, kif.release_pulse);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.cyc != cyc || e.prs != kif.press_pulse ||
            e.rel != kif.release_pulse) begin
          errors++;
          $display("FAIL pulse: got cyc %0d press %b release %b expected cyc %0d press %b release %b",
                   cyc, kif.press_pulse, kif.release_pulse,
                   e.cyc, e.prs, e.rel);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int e;
    kif.pressed = 4'hF;

    // 1: reset value and silent qualification
    repeat (3) @(negedge clk);
    chk("rst_lvl", int'(kif.pressed_lvl), 0);
    chk("rst_press", int'(kif.press_pulse), 0);
    chk("rst_any", int'(kif.any_pressed), 0);
    chk("rst_idx", int'(kif.key_idx), 0);
    rst_n = 1'b1;
    c = cyc;
    wait_to(c + 5);
    chk("rst_lvl_early", int'(kif.pressed_lvl), 0);
    wait_to(c + 6);
    chk("rst_lvl_qual", int'(kif.pressed_lvl), 15);
    chk("rst_any_lag", int'(kif.any_pressed), 0);
    wait_to(c + 7);
    chk("rst_any_set", int'(kif.any_pressed), 1);
    chk("rst_idx0", int'(kif.key_idx), 0);
    kif.pressed = 4'h0;
    expect_ev(c + 13, 4'h0, 4'hF);
    wait_to(c + 15);
    chk("rel_all_lvl", int'(kif.pressed_lvl), 0);
    chk("rel_all_any", int'(kif.any_pressed), 0);

    // 2: clean press on key 1
    c = cyc;
    kif.pressed = 4'b0010;
    expect_ev(c + 6, 4'b0010, 4'h0);
    wait_to(c + 6);
    chk("k1_lvl", int'(kif.pressed_lvl), 2);
    chk("k1_any_lag", int'(kif.any_pressed), 0);
    wait_to(c + 7);
    chk("k1_any", int'(kif.any_pressed), 1);
    chk("k1_idx", int'(kif.key_idx), 1);
    kif.pressed = 4'b0000;
    expect_ev(c + 13, 4'h0, 4'b0010);
    wait_to(c + 15);
    chk("k1_rel_any", int'(kif.any_pressed), 0);

    // 3: three-sample glitch rejected
    c = cyc;
    kif.pressed = 4'b0001;
    wait_to(c + 3);
    kif.pressed = 4'b0000;
    wait_to(c + 10);
    chk("glitch_lvl", int'(kif.pressed_lvl), 0);

    // 3b: exactly four samples is accepted
    c = cyc;
    kif.pressed = 4'b0001;
    expect_ev(c + 6, 4'b0001, 4'h0);
    wait_to(c + 4);
    kif.pressed = 4'b0000;
    expect_ev(c + 10, 4'h0, 4'b0001);
    wait_to(c + 12);
    chk("min_press_lvl", int'(kif.pressed_lvl), 0);

    // 4: bouncing release gives one release strobe
    c = cyc;
    kif.pressed = 4'b0100;
    expect_ev(c + 6, 4'b0100, 4'h0);
    wait_to(c + 8);
    kif.pressed = 4'b0000;
    wait_to(c + 9);
    kif.pressed = 4'b0100;
    wait_to(c + 10);
    kif.pressed = 4'b0000;
    wait_to(c + 11);
    kif.pressed = 4'b0100;
    wait_to(c + 12);
    kif.pressed = 4'b0000;
    expect_ev(c + 18, 4'h0, 4'b0100);
    wait_to(c + 16);
    chk("bounce_lvl_hold", int'(kif.pressed_lvl), 4);
    wait_to(c + 20);
    chk("bounce_lvl_end", int'(kif.pressed_lvl), 0);

    // 5: simultaneous keys 3 and 1
    c = cyc;
    kif.pressed = 4'b1010;
    expect_ev(c + 6, 4'b1010, 4'h0);
    wait_to(c + 7);
    chk("sim_idx1", int'(kif.key_idx), 1);
    kif.pressed = 4'b1000;
    expect_ev(c + 13, 4'h0, 4'b0010);
    wait_to(c + 13);
    chk("sim_lvl", int'(kif.pressed_lvl), 8);
    wait_to(c + 14);
    chk("sim_idx3", int'(kif.key_idx), 3);
    kif.pressed = 4'b0000;
    expect_ev(c + 20, 4'h0, 4'b1000);
    wait_to(c + 22);
    chk("sim_any_end", int'(kif.any_pressed), 0);

    // 6: reset during HELD (key 2) and DEB_P (key 0)
    c = cyc;
    kif.pressed = 4'b0100;
    expect_ev(c + 6, 4'b0100, 4'h0);
    wait_to(c + 8);
    kif.pressed = 4'b0101;
    wait_to(c + 12);
    chk("mid_any_pre", int'(kif.any_pressed), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_lvl", int'(kif.pressed_lvl), 0);
    chk("mid_rst_any", int'(kif.any_pressed), 0);
    chk("mid_rst_idx", int'(kif.key_idx), 0);
    wait_to(c + 15);
    rst_n = 1'b1;
    e = cyc;
    wait_to(e + 5);
    chk("requal_early", int'(kif.pressed_lvl), 0);
    wait_to(e + 6);
    chk("requal_lvl", int'(kif.pressed_lvl), 5);
    wait_to(e + 7);
    chk("requal_any", int'(kif.any_pressed), 1);
    chk("requal_idx", int'(kif.key_idx), 0);
    kif.pressed = 4'b0000;
    expect_ev(e + 13, 4'h0, 4'b0101);
    wait_to(e + 15);

    // 7: long hold on key 3 (repeats only with auto-repeat)
    c = cyc;
    kif.pressed = 4'b1000;
    expect_ev(c + 6, 4'b1000, 4'h0);
`ifdef KEY_AUTOREPEAT_EN
    expect_ev(c + 26, 4'b1000, 4'h0);
    expect_ev(c + 34, 4'b1000, 4'h0);
    expect_ev(c + 42, 4'b1000, 4'h0);
`endif
    wait_to(c + 44);
    chk("hold_lvl", int'(kif.pressed_lvl), 8);
    kif.pressed = 4'b0000;
    expect_ev(c + 50, 4'h0, 4'b1000);
    wait_to(c + 52);

    for (int k = 0; k < 100 && sb.size() != 0; k++) begin
      @(negedge clk);
    end
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
